// File: rtl/masked_subbytes_seq_if.sv
// State-stream bundle: one valid/ready handshake carrying a 128-bit AES state as three Boolean shares.
// The producer drives valid and the shares. The consumer drives ready.
interface masked_subbytes_seq_if;
  logic         valid;
  logic         ready;
  logic [127:0] share1;
  logic [127:0] share2;
  logic [127:0] share3;

  modport master (output valid, output share1, output share2, output share3, input ready);
  modport slave  (input valid, input share1, input share2, input share3, output ready);
endinterface

// File: rtl/masked_subbytes_seq.sv
// Serial SubBytes sequencer for a three-share masked AES S-box.
// It streams one byte per cycle into the S-box, collects the pipelined results and returns the whole state at once.
module masked_subbytes_seq #(
  parameter int SBOX_LAT = 2,
  parameter int NBYTES   = 16
) (
  input  logic       clk,
  input  logic       rst,
  masked_subbytes_seq_if.slave  in_if,
  masked_subbytes_seq_if.master out_if,
  output logic [7:0] sbox_in_share1,
  output logic [7:0] sbox_in_share2,
  output logic [7:0] sbox_in_share3,
  input  logic [7:0] sbox_out_share1,
  input  logic [7:0] sbox_out_share2,
  input  logic [7:0] sbox_out_share3,
  output logic       prng_en
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]       cap_cnt_q, cap_cnt_d;
  logic [SBOX_LAT-1:0] vld_q, vld_d;

  logic accept;
  logic issue_step;
  logic cap_step;
  logic publish;

  // Per-share views so that each share gets its own datapath lane
  logic [W-1:0] in_a     [3];
  logic [W-1:0] out_a    [3];
  logic [7:0]   sbox_in_a  [3];
  logic [7:0]   sbox_out_a [3];

  assign in_a[0]       = in_if.share1;
  assign in_a[1]       = in_if.share2;
  assign in_a[2]       = in_if.share3;
  assign sbox_out_a[0] = sbox_out_share1;
  assign sbox_out_a[1] = sbox_out_share2;
  assign sbox_out_a[2] = sbox_out_share3;
  assign out_if.share1 = out_a[0];
  assign out_if.share2 = out_a[1];
  assign out_if.share3 = out_a[2];
  assign sbox_in_share1 = sbox_in_a[0];
  assign sbox_in_share2 = sbox_in_a[1];
  assign sbox_in_share3 = sbox_in_a[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      vld_q       <= vld_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    cap_cnt_d    = cap_cnt_q;
    accept       = 1'b0;
    issue_step   = 1'b0;
    publish      = 1'b0;
    in_if.ready  = (state_q == IDLE);
    out_if.valid = (state_q == DONE);
    prng_en      = (state_q == ISSUE);

    // A byte sits on the S-box inputs in every ISSUE cycle. Its result emerges SBOX_LAT cycles later.
    vld_d    = (vld_q << 1) | SBOX_LAT'(state_q == ISSUE);
    cap_step = vld_q[SBOX_LAT-1];
    if (cap_step) begin
      cap_cnt_d = cap_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (in_if.valid) begin
          accept      = 1'b1;
          issue_cnt_d = CW'(1);
          cap_cnt_d   = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_cnt_q == CW'(NBYTES)) begin
          state_d = DRAIN;
        end else begin
          issue_step  = 1'b1;
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cap_cnt_q == CW'(NBYTES)) begin
          publish = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_if.ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One lane per share; shares are never combined with each other.
  // The result register is separate from the collect buffer, so a partial result never reaches the output.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      logic [W-1:0] st_q, st_d;
      logic [W-1:0] col_q, col_d;
      logic [W-1:0] res_q, res_d;
      logic [7:0]   sin_q, sin_d;

      always_comb begin
        st_d  = st_q;
        col_d = col_q;
        res_d = res_q;
        sin_d = 8'h00;
        if (accept) begin
          sin_d = in_a[gi][7:0];
          st_d  = in_a[gi] >> 8;
        end else if (issue_step) begin
          sin_d = st_q[7:0];
          st_d  = st_q >> 8;
        end
        if (cap_step) begin
          col_d = {sbox_out_a[gi], col_q[W-1:8]};
        end
        if (publish) begin
          res_d = col_q;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          st_q  <= '0;
          col_q <= '0;
          res_q <= '0;
          sin_q <= 8'h00;
        end else begin
          st_q  <= st_d;
          col_q <= col_d;
          res_q <= res_d;
          sin_q <= sin_d;
        end
      end

      assign sbox_in_a[gi] = sin_q;
      assign out_a[gi]     = res_q;
    end
  endgenerate

endmodule

// File: tb/tb_masked_subbytes_seq.sv
// Bench for masked_subbytes_seq: a behavioural two-stage masked S-box fed by an LFSR is attached.
// Results are checked against an AES S-box computed from GF(2^8) arithmetic.
module tb_masked_subbytes_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  masked_subbytes_seq_if in_if ();
  masked_subbytes_seq_if out_if ();

  logic [7:0] sbi1, sbi2, sbi3, sbo1, sbo2, sbo3;
  logic       prng_en;

  masked_subbytes_seq #(.SBOX_LAT(2), .NBYTES(16)) dut (
    .clk(clk), .rst(rst), .in_if(in_if), .out_if(out_if),
    .sbox_in_share1(sbi1), .sbox_in_share2(sbi2), .sbox_in_share3(sbi3),
    .sbox_out_share1(sbo1), .sbox_out_share2(sbo2), .sbox_out_share3(sbo3),
    .prng_en(prng_en)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] snap1, snap2, snap3;
  time last_acc_t = 0;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] v);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gf_mul(v, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_subbytes(input logic [127:0] p);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = aes_sbox(p[8*i +: 8]);
    return r;
  endfunction

  // Attached S-box stand-in: two register stages, output re-shared with LFSR masks
  logic [15:0] lfsr;
  logic [7:0]  p1_t, p1_m1, p1_m2;
  always @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else if (prng_en) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    p1_t  <= aes_sbox(sbi1 ^ sbi2 ^ sbi3);
    p1_m1 <= lfsr[7:0];
    p1_m2 <= lfsr[15:8];
    sbo1  <= p1_t ^ p1_m1;
    sbo2  <= p1_m1 ^ p1_m2;
    sbo3  <= p1_m2;
  end

  task automatic check_eq(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_state(input logic [127:0] s1, input logic [127:0] s2, input logic [127:0] s3,
                           input int hold, input bit b2b, input bit chk_gap,
                           output logic [127:0] unm);
    logic [127:0] expv, h1, h2, h3;
    int n, lat, w, prng_cnt, iss_bad, zero_bad, rdy_bad, part_bad, stall_bad;
    expv = ref_subbytes(s1 ^ s2 ^ s3);
    unm = '0;
    in_if.share1 = s1; in_if.share2 = s2; in_if.share3 = s3;
    in_if.valid  = 1'b1;
    out_if.ready = (hold == 0);
    w = 0;
    while (!in_if.ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_if.ready) begin
      check_eq("accept_wait", in_if.ready, 1);
      return;
    end
    @(posedge clk);
    if (chk_gap) check_eq("accept_gap", ($time - last_acc_t) / 10, 21);
    last_acc_t = $time;
    #1;
    if (b2b) begin
      in_if.share1 = rand128(); in_if.share2 = rand128(); in_if.share3 = rand128();
    end else begin
      in_if.valid = 1'b0;
    end
    prng_cnt = 0; iss_bad = 0; zero_bad = 0; rdy_bad = 0; part_bad = 0; stall_bad = 0;
    n = 0; lat = -1;
    while (n < 40) begin
      @(negedge clk);
      if (prng_en) prng_cnt++;
      if (n < 16) begin
        if ({sbi1, sbi2, sbi3} != {s1[8*n +: 8], s2[8*n +: 8], s3[8*n +: 8]}) iss_bad++;
      end else if ({sbi1, sbi2, sbi3} != 24'h0) zero_bad++;
      if (out_if.valid) begin
        lat = n;
        break;
      end
      if (in_if.ready) rdy_bad++;
      if ({out_if.share1, out_if.share2, out_if.share3} != {snap1, snap2, snap3}) part_bad++;
      n++;
    end
    check_eq("latency", lat, 19);
    if (lat < 0) return;
    h1 = out_if.share1; h2 = out_if.share2; h3 = out_if.share3;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!out_if.valid || in_if.ready) stall_bad++;
      if ({out_if.share1, out_if.share2, out_if.share3} != {h1, h2, h3}) stall_bad++;
      if ({sbi1, sbi2, sbi3} != 24'h0) zero_bad++;
      if (prng_en) prng_cnt++;
    end
    out_if.ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("idle_ready", in_if.ready, 1);
    check_eq("idle_valid", out_if.valid, 0);
    check_eq("out_keep", {out_if.share1, out_if.share2, out_if.share3}, {h1, h2, h3});
    check_eq("prng_cycles", prng_cnt, 16);
    check_eq("issue_bytes", iss_bad, 0);
    check_eq("sbox_in_zero", zero_bad, 0);
    check_eq("busy_ready", rdy_bad, 0);
    check_eq("no_partial", part_bad, 0);
    check_eq("stall_hold", stall_bad, 0);
    unm = h1 ^ h2 ^ h3;
    check_eq("result", unm, expv);
    $display("txn in=%h out=%h lat=%0d hold=%0d", s1 ^ s2 ^ s3, unm, lat, hold);
    snap1 = h1; snap2 = h2; snap3 = h3;
  endtask

  task automatic reset_midway();
    int w;
    in_if.share1 = rand128(); in_if.share2 = rand128(); in_if.share3 = rand128();
    in_if.valid = 1'b1;
    out_if.ready = 1'b1;
    w = 0;
    while (!in_if.ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 in_if.valid = 1'b0;
    repeat (7) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_ready", in_if.ready, 1);
    check_eq("rst_mid_valid", out_if.valid, 0);
    check_eq("rst_mid_prng", prng_en, 0);
    check_eq("rst_mid_sbox_in", {sbi1, sbi2, sbi3}, 24'h0);
    check_eq("rst_mid_out", {out_if.share1, out_if.share2, out_if.share3}, 384'h0);
    $display("txn reset asserted in ISSUE cycle 8");
    snap1 = '0; snap2 = '0; snap3 = '0;
  endtask

  initial begin
    logic [127:0] unm, p, r1, r2;
    logic [127:0] kat;
    int prev_hold, hold;
    bit b2b;
    kat = 128'h76ABD7FE2B670130C56F6BF27B777C63;
    p   = 128'h0F0E0D0C0B0A09080706050403020100;
    rst = 1'b1;
    in_if.valid = 1'b0;
    in_if.share1 = '0; in_if.share2 = '0; in_if.share3 = '0;
    out_if.ready = 1'b0;
    snap1 = '0; snap2 = '0; snap3 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", in_if.ready, 1);
    check_eq("rst_valid", out_if.valid, 0);
    check_eq("rst_prng", prng_en, 0);
    check_eq("rst_sbox_in", {sbi1, sbi2, sbi3}, 24'h0);
    check_eq("rst_out", {out_if.share1, out_if.share2, out_if.share3}, 384'h0);
    rst = 1'b0;
    @(negedge clk);

    run_state('0, '0, '0, 0, 1'b0, 1'b0, unm);
    check_eq("zero_63", unm, {16{8'h63}});

    for (int rep = 0; rep < 50; rep++) begin
      r1 = rand128();
      r2 = rand128();
      run_state(r1, r2, p ^ r1 ^ r2, 0, rep[0], rep > 0, unm);
      check_eq("kat", unm, kat);
    end

    run_state(rand128(), rand128(), rand128(), 5, 1'b0, 1'b0, unm);

    reset_midway();
    run_state(rand128(), rand128(), rand128(), 0, 1'b0, 1'b0, unm);

    prev_hold = 0;
    for (int t = 0; t < 12; t++) begin
      hold = $urandom_range(0, 3);
      b2b  = 1'($urandom_range(0, 1));
      run_state(rand128(), rand128(), rand128(), hold, b2b, prev_hold == 0, unm);
      prev_hold = hold;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
